// File: rtl/cacheline_adaptor.sv
// rtl/cacheline_adaptor.sv - cache line <-> memory burst adaptor (line fill and write-back)
module cacheline_adaptor #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        address_i,
  input  logic [LINE_W-1:0]  line_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic [LINE_W-1:0]  line_o,
  output logic               resp_o,
  output logic [31:0]        address_o,
  input  logic [BURST_W-1:0] burst_i,
  output logic [BURST_W-1:0] burst_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
);

  localparam int BEATS = LINE_W / BURST_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [31:0]       r_addr;
  logic [LINE_W-1:0] r_line;
  logic [LINE_W-1:0] r_wline;
  logic              w_last_beat;
  logic              w_unused_addr_lsbs;

  // Addresses are line-aligned on 32-byte boundaries; the low bits are dropped.
  assign w_unused_addr_lsbs = ^address_i[4:0];
  assign w_last_beat        = resp_i && (r_cnt == LAST_BEAT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (read_i)       w_next = READ;
        else if (write_i) w_next = WRITE;
      end
      READ:    if (w_last_beat) w_next = DONE;
      WRITE:   if (w_last_beat) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    read_o  = 1'b0;
    write_o = 1'b0;
    resp_o  = 1'b0;
    case (r_state)
      READ:    read_o  = 1'b1;
      WRITE:   write_o = 1'b1;
      DONE:    resp_o  = 1'b1;
      default: ;
    endcase
  end

  // Beat counter, latched request and line storage; stalls (resp_i=0) hold everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_addr  <= '0;
      r_line  <= '0;
      r_wline <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (read_i || write_i) begin
            r_addr <= {address_i[31:5], 5'b0};
            r_cnt  <= '0;
            if (!read_i) r_wline <= line_i;
          end
        end
        READ: begin
          if (resp_i) begin
            r_cnt <= w_last_beat ? '0 : r_cnt + 1'b1;
            for (int b = 0; b < BEATS; b++) begin
              if (r_cnt == CNT_W'(b)) r_line[b*BURST_W +: BURST_W] <= burst_i;
            end
          end
        end
        WRITE: begin
          if (resp_i) r_cnt <= w_last_beat ? '0 : r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    burst_o = '0;
    for (int b = 0; b < BEATS; b++) begin
      if (r_cnt == CNT_W'(b)) burst_o = r_wline[b*BURST_W +: BURST_W];
    end
  end

  assign line_o    = r_line;
  assign address_o = r_addr;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// tb/tb_cacheline_adaptor.sv - scoreboard bench for cacheline_adaptor
module tb_cacheline_adaptor;
  localparam int LINE_W  = 256;
  localparam int BURST_W = 64;
  localparam int BEATS   = LINE_W / BURST_W;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [31:0]        address_i = '0;
  logic [LINE_W-1:0]  line_i = '0;
  logic               read_i = 1'b0;
  logic               write_i = 1'b0;
  logic [LINE_W-1:0]  line_o;
  logic               resp_o;
  logic [31:0]        address_o;
  logic [BURST_W-1:0] burst_i = '0;
  logic [BURST_W-1:0] burst_o;
  logic               read_o;
  logic               write_o;
  logic               resp_i = 1'b0;

  cacheline_adaptor #(.LINE_W(LINE_W), .BURST_W(BURST_W)) dut (
    .clk(clk), .rst_n(rst_n), .address_i(address_i), .line_i(line_i),
    .read_i(read_i), .write_i(write_i), .line_o(line_o), .resp_o(resp_o),
    .address_o(address_o), .burst_i(burst_i), .burst_o(burst_o),
    .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit                rd;
    logic [LINE_W-1:0] line;
    logic [31:0]       addr;
  } exp_t;

  exp_t              sb[$];
  int                vecs = 0;
  int                errs = 0;
  logic [LINE_W-1:0] model_line = '0;
  logic [31:0]       model_addr = '0;

  task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [BURST_W-1:0] rand_beat();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] l;
    for (int i = 0; i < LINE_W / 32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  // Monitor: every resp_o pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && resp_o) begin
      if (sb.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL unexpected_resp: resp_o=1 with no transaction outstanding, expected 0");
      end else begin
        e = sb.pop_front();
        chk(e.rd ? "resp_line_read" : "resp_line_write", line_o, e.line);
        chk("resp_addr", address_o, e.addr);
      end
    end
  end

  // One transaction: data is the fill line (read) or write-back line; st[k] = stall cycles before beat k.
  task automatic txn(input bit rd, input bit wr, input logic [31:0] addr,
                     input logic [LINE_W-1:0] data, input int st[BEATS]);
    bit          is_rd = rd;
    logic [31:0] a = {addr[31:5], 5'b0};
    exp_t        e;
    read_i    = rd;
    write_i   = wr;
    address_i = addr;
    line_i    = data;
    @(posedge clk); #1;
    for (int k = 0; k < BEATS; k++) begin
      for (int s = 0; s <= st[k]; s++) begin
        resp_i    = (s == st[k]);
        burst_i   = resp_i ? data[k*BURST_W +: BURST_W] : rand_beat();
        read_i    = 1'($urandom_range(0, 1));
        write_i   = 1'($urandom_range(0, 1));
        address_i = $urandom;
        line_i    = rand_line();
        @(negedge clk);
        chk("read_o_busy", read_o, is_rd);
        chk("write_o_busy", write_o, !is_rd);
        chk("resp_o_busy", resp_o, 1'b0);
        chk("address_o_busy", address_o, a);
        if (!is_rd) begin
          chk("burst_o", burst_o, data[k*BURST_W +: BURST_W]);
          chk("line_o_during_write", line_o, model_line);
        end
        @(posedge clk); #1;
      end
    end
    if (is_rd) model_line = data;
    model_addr = a;
    e.rd   = is_rd;
    e.line = model_line;
    e.addr = a;
    sb.push_back(e);
    resp_i  = 1'($urandom_range(0, 1));
    burst_i = rand_beat();
    read_i  = 1'b0;
    write_i = 1'b0;
    @(negedge clk);
    chk("resp_o_done", resp_o, 1'b1);
    chk("read_o_done", read_o, 1'b0);
    chk("write_o_done", write_o, 1'b0);
    @(posedge clk); #1;
    resp_i = 1'b0;
  endtask

  initial begin
    int nost[BEATS];
    int st[BEATS];
    logic [LINE_W-1:0] d;
    foreach (nost[i]) nost[i] = 0;

    // Reset state, before any clock edge matters
    #3;
    chk("rst_read_o", read_o, 1'b0);
    chk("rst_write_o", write_o, 1'b0);
    chk("rst_resp_o", resp_o, 1'b0);
    chk("rst_line_o", line_o, '0);
    chk("rst_address_o", address_o, '0);
    chk("rst_burst_o", burst_o, '0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Plain read with fixed beats, then a write-back raised right after
    d = {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}};
    txn(1'b1, 1'b0, 32'h0000_1234, d, nost);
    chk("read_fixed_addr", model_addr, 32'h0000_1220);
    st[0] = 0; st[1] = 1; st[2] = 2; st[3] = 0;
    txn(1'b0, 1'b1, 32'h0000_5678, {64'hD3D3_0000_0000_0003, 64'hD2D2_0000_0000_0002,
                                    64'hD1D1_0000_0000_0001, 64'hD0D0_0000_0000_0000}, st);
    chk("read_fixed_line_kept", line_o, d);

    // Simultaneous read and write: read wins
    txn(1'b1, 1'b1, 32'hABCD_EF17, rand_line(), nost);

    // Stray strobes in IDLE change nothing
    resp_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      burst_i = rand_beat();
      @(negedge clk);
      chk("stray_resp_o", resp_o, 1'b0);
      chk("stray_read_o", read_o, 1'b0);
      chk("stray_write_o", write_o, 1'b0);
      chk("stray_line_o", line_o, model_line);
      chk("stray_address_o", address_o, model_addr);
      @(posedge clk); #1;
    end
    resp_i = 1'b0;
    txn(1'b1, 1'b0, 32'h0000_0040, rand_line(), nost);

    // Asynchronous reset after two read beats
    read_i = 1'b1;
    address_i = 32'h1111_2222;
    @(posedge clk); #1;
    read_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      resp_i = 1'b1;
      burst_i = rand_beat();
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_read_o", read_o, 1'b0);
    chk("midrst_resp_o", resp_o, 1'b0);
    chk("midrst_line_o", line_o, '0);
    chk("midrst_address_o", address_o, '0);
    chk("midrst_burst_o", burst_o, '0);
    model_line = '0;
    model_addr = '0;
    resp_i = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    txn(1'b1, 1'b0, 32'h0000_2000, rand_line(), nost);

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      bit rd;
      bit wr;
      rd = 1'($urandom_range(0, 1));
      wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
      foreach (st[i]) st[i] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
      txn(rd, wr, $urandom, rand_line(), st);
      repeat ($urandom_range(0, 2)) begin
        resp_i = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
      resp_i = 1'b0;
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
